issue_broadcaster: RTL and testbench
====================================

// Module: issue_broadcaster
// PURPOSE
//  Consumer side of the positioner placement interface. Once a positioning round is complete,
//   latches the window bounds (x_min..x_max, y_min..y_max, padded coordinates).
//  Scans that window row-major and reads in-image pixels from the image buffer.
//  Broadcasts (x, y, data) to all allocators; padding pixels are sent as zero.
//  Ends the round by pulsing advance (more rounds) or layer_done (last round).
// PARAMETERS
//  ADDR_W   16  image buffer address width
//  PIXEL_W  16  pixel data width
// PORTS
//  clk              in   1        clock
//  rst_n            in   1        synchronous reset, active-low
//  image_dim        in   8        unpadded image side length
//  padding          in   2        filter halfsize; padded coordinate offset
//  x_min, x_max     in   8 each   window column bounds, inclusive, padded space
//  y_min, y_max     in   8 each   window row bounds, inclusive, padded space
//  round_start      in   1        pulse: bounds stable, start broadcast
//  positioner_done  in   1        high: current round is the last of the layer
//  stall            in   1        allocators cannot take a new coordinate this cycle
//  mem_rd_en        out  1        image buffer read strobe
//  mem_rd_addr      out  ADDR_W   row-major address (y-padding)*image_dim+(x-padding)
//  mem_rd_data      in   PIXEL_W  read data, valid exactly 1 cycle after mem_rd_en
//  pixel_valid      out  1        broadcast beat valid
//  pixel_x, pixel_y out  8 each   padded coordinate of the beat
//  pixel_data       out  PIXEL_W  pixel value; 0 for padding positions
//  busy             out  1        high in any state other than IDLE
//  advance          out  1        1-cycle pulse: round done, positioner may proceed
//  layer_done       out  1        1-cycle pulse: last round of the layer done
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; in-flight read dropped.
//   Applies at any point mid-round.
//  FSM states: IDLE, SCAN, DRAIN, FINISH.
//   IDLE->SCAN on round_start: latch bounds, padding, image_dim, positioner_done;
//     cursor=(x_min, y_min).
//   round_start is ignored unless the FSM is in IDLE.
//   Empty window (x_min>x_max or y_min>y_max): IDLE->FINISH directly. No reads, no beats.
//  SCAN: each cycle with stall=0 issues the cursor.
//   In-image (padding<=x<image_dim+padding, same for y): mem_rd_en=1 with the address.
//   Otherwise mem_rd_en=0 and the beat is marked zero.
//   Cursor advance: x++; when x==x_max, x wraps to x_min and y++.
//   stall=1: cursor held, mem_rd_en=0, nothing issued. No coordinate is skipped or repeated.
//  Issue of (x_max, y_max) -> DRAIN.
//  Output stage (1 cycle): the beat issued at cycle t appears at t+1.
//   pixel_valid=1, pixel_x/pixel_y = issued coordinate.
//   pixel_data = mem_rd_data if read, else 0.
//   Cycles with no issue: pixel_valid=0; x/y/data hold their last values.
//  DRAIN -> FINISH after 1 cycle, in which the last beat is emitted.
//  FINISH: pulses advance if the latched positioner_done=0, else layer_done. Returns to IDLE next cycle.
//  Latency: round_start at T -> first issue at T+1 -> first beat at T+2.
//   Last issue at L -> last beat at L+1 -> advance/layer_done at L+2.
//   Empty window: pulse at T+1.
//  Throughput: 1 beat/cycle without stall.
//  Arithmetic: address uses an 8x8 product zero-extended to ADDR_W.
//   Coordinates use 8-bit unsigned compares.
//   x_max=255 wraps correctly: the compare is on equality, not on overflow.
//  At most one of advance and layer_done is high in any cycle. busy=0 only in IDLE.
// TESTING
//  1. dim=4, pad=0, window x0..1, y0..1
//     -> addrs 0,1,4,5 on consecutive cycles; beats (0,0)(1,0)(0,1)(1,1) with memory data;
//        advance 2 cycles after addr 5.
//  2. dim=3, pad=1, window 0..2 x 0..2
//     -> beat (0,0) data 0 with no rd_en; (1,1) reads addr 0; (2,2) reads addr 4;
//        9 beats total.
//  3. Case 1 with stall high for 3 cycles after the 2nd issue
//     -> same 4 beats in order, no duplicates; advance delayed by 3 cycles.
//  4. positioner_done=1 at round_start -> layer_done pulse, advance stays 0.
//  5. x_min=255, x_max=0 -> no rd_en, no beats; advance at T+1.
//     round_start while busy -> ignored.
//  6. rst_n low for 1 cycle mid-SCAN -> all outputs 0 next cycle.
//     A following round_start completes case 1 correctly.

Source files
------------

// File: rtl/issue_broadcaster_if.sv
// Bundle between the broadcaster and its environment: window setup, round control,
// image buffer read port and the broadcast stream to the allocators.
interface issue_broadcaster_if #(
    parameter int ADDR_W  = 16,
    parameter int PIXEL_W = 16
);
    logic [7:0]         image_dim;
    logic [1:0]         padding;
    logic [7:0]         x_min;
    logic [7:0]         x_max;
    logic [7:0]         y_min;
    logic [7:0]         y_max;
    logic               round_start;
    logic               positioner_done;
    logic               stall;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_rd_addr;
    logic [PIXEL_W-1:0] mem_rd_data;
    logic               pixel_valid;
    logic [7:0]         pixel_x;
    logic [7:0]         pixel_y;
    logic [PIXEL_W-1:0] pixel_data;
    logic               busy;
    logic               advance;
    logic               layer_done;

    modport master (
        input  image_dim, padding, x_min, x_max, y_min, y_max,
        input  round_start, positioner_done, stall, mem_rd_data,
        output mem_rd_en, mem_rd_addr, pixel_valid, pixel_x, pixel_y, pixel_data,
        output busy, advance, layer_done
    );

    modport slave (
        output image_dim, padding, x_min, x_max, y_min, y_max,
        output round_start, positioner_done, stall, mem_rd_data,
        input  mem_rd_en, mem_rd_addr, pixel_valid, pixel_x, pixel_y, pixel_data,
        input  busy, advance, layer_done
    );
endinterface

// File: rtl/issue_broadcaster.sv
// Scans a padded-coordinate window row-major, reads in-image pixels from the image
// buffer and broadcasts (x, y, data) beats; padding positions are sent as zero.
module issue_broadcaster #(
    parameter int ADDR_W  = 16,
    parameter int PIXEL_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    issue_broadcaster_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SCAN   = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    logic [1:0]         state_reg, state_next;
    logic [7:0]         x_min_reg, x_max_reg, y_max_reg, dim_reg;
    logic [1:0]         pad_reg;
    logic               last_reg;
    logic [7:0]         x_reg, y_reg;

    logic               beat_valid_reg, beat_rd_reg;
    logic [7:0]         beat_x_reg, beat_y_reg;
    logic [PIXEL_W-1:0] data_hold_reg;

    logic               start, empty_window, issue, in_image, wrap_x;
    logic [8:0]         x_ext, y_ext, pad_ext, lim_ext;
    logic [7:0]         row, col;
    logic [15:0]        prod;
    logic [PIXEL_W-1:0] beat_data;

    assign start        = (state_reg == IDLE) && bus.round_start;
    assign empty_window = (bus.x_min > bus.x_max) || (bus.y_min > bus.y_max);
    assign issue        = (state_reg == SCAN) && !bus.stall;
    // Equality compare so a window ending at 255 wraps without relying on overflow.
    assign wrap_x       = (x_reg == x_max_reg);

    assign x_ext    = {1'b0, x_reg};
    assign y_ext    = {1'b0, y_reg};
    assign pad_ext  = {7'd0, pad_reg};
    assign lim_ext  = {1'b0, dim_reg} + pad_ext;
    assign in_image = (x_ext >= pad_ext) && (x_ext < lim_ext) &&
                      (y_ext >= pad_ext) && (y_ext < lim_ext);

    assign row  = y_reg - {6'd0, pad_reg};
    assign col  = x_reg - {6'd0, pad_reg};
    assign prod = {8'd0, row} * {8'd0, dim_reg};

    assign bus.mem_rd_en   = issue && in_image;
    assign bus.mem_rd_addr = bus.mem_rd_en ? (ADDR_W'(prod) + ADDR_W'(col)) : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.round_start) state_next = empty_window ? FINISH : SCAN;
            SCAN:    if (issue && wrap_x && (y_reg == y_max_reg)) state_next = DRAIN;
            DRAIN:   state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            x_min_reg      <= '0;
            x_max_reg      <= '0;
            y_max_reg      <= '0;
            dim_reg        <= '0;
            pad_reg        <= '0;
            last_reg       <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
            beat_valid_reg <= 1'b0;
            beat_rd_reg    <= 1'b0;
            beat_x_reg     <= '0;
            beat_y_reg     <= '0;
            data_hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                x_min_reg <= bus.x_min;
                x_max_reg <= bus.x_max;
                y_max_reg <= bus.y_max;
                dim_reg   <= bus.image_dim;
                pad_reg   <= bus.padding;
                last_reg  <= bus.positioner_done;
                x_reg     <= bus.x_min;
                y_reg     <= bus.y_min;
            end else if (issue) begin
                if (wrap_x) begin
                    x_reg <= x_min_reg;
                    y_reg <= y_reg + 8'd1;
                end else begin
                    x_reg <= x_reg + 8'd1;
                end
            end
            // Output stage: one beat per issue, visible the following cycle.
            beat_valid_reg <= issue;
            beat_rd_reg    <= issue && in_image;
            if (issue) begin
                beat_x_reg <= x_reg;
                beat_y_reg <= y_reg;
            end
            if (beat_valid_reg) data_hold_reg <= beat_data;
        end
    end

    // Read data is only valid in the beat cycle, so it is captured for the hold.
    assign beat_data = beat_rd_reg ? bus.mem_rd_data : '0;

    assign bus.pixel_valid = beat_valid_reg;
    assign bus.pixel_x     = beat_x_reg;
    assign bus.pixel_y     = beat_y_reg;
    assign bus.pixel_data  = beat_valid_reg ? beat_data : data_hold_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.advance     = (state_reg == FINISH) && !last_reg;
    assign bus.layer_done  = (state_reg == FINISH) && last_reg;
endmodule

// File: tb/tb_issue_broadcaster.sv
// Directed and randomized rounds checked cycle by cycle against a window-list model.
module tb_issue_broadcaster;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    issue_broadcaster_if #(.ADDR_W(16), .PIXEL_W(16)) bus ();

    issue_broadcaster #(.ADDR_W(16), .PIXEL_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr[9:0]];
        else               bus.mem_rd_data <= 16'($urandom);
    end

    int checks = 0;
    int fails  = 0;
    int last_x = 0, last_y = 0, last_d = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},   bus.mem_rd_en, 0);
        check({tag, "_addr"},    bus.mem_rd_addr, 0);
        check({tag, "_valid"},   bus.pixel_valid, 0);
        check({tag, "_x"},       bus.pixel_x, 0);
        check({tag, "_y"},       bus.pixel_y, 0);
        check({tag, "_data"},    bus.pixel_data, 0);
        check({tag, "_busy"},    bus.busy, 0);
        check({tag, "_advance"}, bus.advance, 0);
        check({tag, "_layer"},   bus.layer_done, 0);
    endtask

    // Entered just after a rising edge with the DUT idle.
    task automatic run_round(input int dim, input int pad, input int xmn, input int xmx,
                             input int ymn, input int ymx, input bit last,
                             input int smode, input int poke, input int rst_cyc);
        int qx[$], qy[$];
        int n, idx, pulse, cyc, st3, px, py, pd, nbeats;
        bit have_prev, issue, inimg, stall_v;
        int addr;
        for (int y = ymn; y <= ymx; y++)
            for (int x = xmn; x <= xmx; x++) begin
                qx.push_back(x);
                qy.push_back(y);
            end
        n = qx.size();
        idx = 0; st3 = 0; have_prev = 0; nbeats = 0; px = 0; py = 0; pd = 0;
        pulse = (n == 0) ? 1 : -1;

        bus.image_dim = 8'(dim); bus.padding = 2'(pad);
        bus.x_min = 8'(xmn); bus.x_max = 8'(xmx);
        bus.y_min = 8'(ymn); bus.y_max = 8'(ymx);
        bus.positioner_done = last; bus.round_start = 1'b1; bus.stall = 1'b0;
        @(negedge clk);
        check("start_busy", bus.busy, 0);
        @(posedge clk); #1;

        for (cyc = 1; cyc < 3000; cyc++) begin
            bus.round_start = (cyc == poke);
            bus.image_dim = 8'($urandom); bus.padding = 2'($urandom);
            bus.x_min = 8'($urandom); bus.x_max = 8'($urandom);
            bus.y_min = 8'($urandom); bus.y_max = 8'($urandom);
            bus.positioner_done = 1'($urandom);
            if (smode == 1)
                stall_v = ($urandom_range(0, 3) == 0);
            else if (smode == 2 && idx == 2 && st3 < 3) begin
                stall_v = 1'b1;
                st3++;
            end else
                stall_v = 1'b0;
            bus.stall = stall_v;
            if (cyc == rst_cyc) rst_n = 1'b0;

            issue = !stall_v && (idx < n);
            inimg = 0; addr = 0;
            if (issue) begin
                inimg = (qx[idx] >= pad) && (qx[idx] < dim + pad) &&
                        (qy[idx] >= pad) && (qy[idx] < dim + pad);
                addr = (qy[idx] - pad) * dim + (qx[idx] - pad);
            end

            @(negedge clk);
            check("rd_en", bus.mem_rd_en, inimg);
            if (inimg) check("rd_addr", bus.mem_rd_addr, addr);
            check("pixel_valid", bus.pixel_valid, have_prev);
            if (have_prev) begin
                check("pixel_x", bus.pixel_x, px);
                check("pixel_y", bus.pixel_y, py);
                check("pixel_data", bus.pixel_data, pd);
                last_x = px; last_y = py; last_d = pd;
                nbeats++;
            end else begin
                check("hold_x", bus.pixel_x, last_x);
                check("hold_y", bus.pixel_y, last_y);
                check("hold_data", bus.pixel_data, last_d);
            end
            check("advance", bus.advance, (cyc == pulse) && !last);
            check("layer_done", bus.layer_done, (cyc == pulse) && last);
            check("busy", bus.busy, 1);

            have_prev = issue;
            if (issue) begin
                px = qx[idx]; py = qy[idx];
                pd = inimg ? int'(mem[addr]) : 0;
                idx++;
                if (idx == n) pulse = cyc + 2;
            end
            @(posedge clk); #1;
            if (cyc == rst_cyc) begin
                rst_n = 1'b1;
                bus.round_start = 1'b0;
                @(negedge clk);
                check_idle_outputs("after_reset");
                last_x = 0; last_y = 0; last_d = 0;
                $display("round dim=%0d pad=%0d x=%0d..%0d y=%0d..%0d reset at cycle %0d",
                         dim, pad, xmn, xmx, ymn, ymx, cyc);
                @(posedge clk); #1;
                return;
            end
            if (cyc == pulse) break;
        end
        check("round_timeout", (cyc < 3000), 1);
        bus.round_start = 1'b0; bus.stall = 1'b0;
        @(negedge clk);
        check("end_busy", bus.busy, 0);
        check("end_valid", bus.pixel_valid, 0);
        check("end_advance", bus.advance, 0);
        check("end_layer", bus.layer_done, 0);
        check("beat_count", nbeats, n);
        $display("round dim=%0d pad=%0d x=%0d..%0d y=%0d..%0d last=%0d beats=%0d cycles=%0d",
                 dim, pad, xmn, xmx, ymn, ymx, last, nbeats, cyc);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        rst_n = 1'b0;
        bus.image_dim = '0; bus.padding = '0; bus.x_min = '0; bus.x_max = '0;
        bus.y_min = '0; bus.y_max = '0; bus.round_start = 1'b0;
        bus.positioner_done = 1'b0; bus.stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_round(4, 0, 0, 1, 0, 1, 0, 0, -1, -1);      // basic 2x2 window
        run_round(3, 1, 0, 2, 0, 2, 0, 0, -1, -1);      // padded border
        run_round(4, 0, 0, 1, 0, 1, 0, 2, -1, -1);      // 3-cycle stall after 2nd issue
        run_round(4, 0, 0, 1, 0, 1, 1, 0, -1, -1);      // last round -> layer_done
        run_round(4, 0, 255, 0, 0, 1, 0, 0, -1, -1);    // empty window
        run_round(3, 1, 0, 2, 0, 2, 0, 0, 3, -1);       // round_start while busy
        run_round(4, 0, 253, 255, 0, 1, 0, 1, -1, -1);  // x_max=255 wrap
        run_round(4, 0, 0, 1, 0, 1, 0, 0, -1, 2);       // reset mid-scan
        run_round(4, 0, 0, 1, 0, 1, 0, 0, -1, -1);      // clean round after reset

        for (int r = 0; r < 10; r++) begin
            int dim, pad, span;
            dim  = $urandom_range(2, 10);
            pad  = $urandom_range(0, 3);
            span = dim + 2 * pad;
            run_round(dim, pad, $urandom_range(0, span - 1), $urandom_range(0, span - 1),
                      $urandom_range(0, span - 1), $urandom_range(0, span - 1),
                      1'($urandom), 1, -1, -1);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
